// File: rtl/expr_checker.sv
// Purpose : streaming syntax recogniser for arithmetic expressions, one ASCII char per in_valid cycle.
// Latency : the char sampled at edge N shows on out/err/depth/num_cnt right after edge N (Moore outputs).
// Backpress: none; every in_valid char is consumed, in_valid=0 holds all state. Parens need EXPR_CHECKER_PAREN_EN.
module expr_checker #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 3,
  parameter int CNT_W      = 8,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               out,
  output logic               err,
  output logic [DEPTH_W-1:0] depth,
  output logic [CNT_W-1:0]   num_cnt
);

  // Digit counter only has to reach MAX_DIGITS; the extra digit goes to S_ERR, never counted.
  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [DCNT_W-1:0] MAX_DIG_C = DCNT_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_OPND  = 2'd0,
    S_NUM   = 2'd1,
    S_CLOSE = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic [CNT_W-1:0]    num_cnt_q, num_cnt_d;
  logic [CNT_W-1:0]    num_cnt_inc;

  logic is_dig;
  logic is_op;

`ifdef EXPR_CHECKER_PAREN_EN
  localparam logic [DEPTH_W-1:0] MAX_DEP_C = DEPTH_W'(MAX_DEPTH);
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic is_lp;
  logic is_rp;
`endif

  // Classify the incoming character; anything outside these classes is illegal everywhere.
  always_comb begin
    is_dig = (in >= 8'h30) && (in <= 8'h39);
    is_op  = (in == 8'h2B) || (in == 8'h2D) || (in == 8'h2A) || (in == 8'h2F);
`ifdef EXPR_CHECKER_PAREN_EN
    is_lp  = (in == 8'h28);
    is_rp  = (in == 8'h29);
`endif
  end

  // Saturating operand count: sticks at all-ones instead of wrapping.
  always_comb begin
    num_cnt_inc = (num_cnt_q == {CNT_W{1'b1}}) ? num_cnt_q : num_cnt_q + CNT_W'(1);
  end

  // State register: clr wins over in_valid, so a char arriving with clr is dropped.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_OPND;
      dcnt_q    <= '0;
      num_cnt_q <= '0;
`ifdef EXPR_CHECKER_PAREN_EN
      depth_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      num_cnt_q <= num_cnt_d;
`ifdef EXPR_CHECKER_PAREN_EN
      depth_q   <= depth_d;
`endif
    end
  end

  // Next-state logic; entering S_ERR leaves depth and num_cnt untouched so they freeze there.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    num_cnt_d = num_cnt_q;
`ifdef EXPR_CHECKER_PAREN_EN
    depth_d   = depth_q;
`endif
    if (in_valid) begin
      case (state_q)
        S_OPND: begin
          if (is_dig) begin
            state_d   = S_NUM;
            dcnt_d    = DCNT_W'(1);
            num_cnt_d = num_cnt_inc;
          end
`ifdef EXPR_CHECKER_PAREN_EN
          else if (is_lp && (depth_q != MAX_DEP_C)) begin
            depth_d = depth_q + DEPTH_W'(1);
          end
`endif
          else begin
            state_d = S_ERR;
          end
        end

        S_NUM: begin
          if (is_dig) begin
            if (dcnt_q < MAX_DIG_C) begin
              dcnt_d = dcnt_q + DCNT_W'(1);
            end else begin
              state_d = S_ERR;
            end
          end else if (is_op) begin
            state_d = S_OPND;
            dcnt_d  = '0;
          end
`ifdef EXPR_CHECKER_PAREN_EN
          else if (is_rp && (depth_q != '0)) begin
            state_d = S_CLOSE;
            dcnt_d  = '0;
            depth_d = depth_q - DEPTH_W'(1);
          end
`endif
          else begin
            state_d = S_ERR;
          end
        end

`ifdef EXPR_CHECKER_PAREN_EN
        S_CLOSE: begin
          if (is_op) begin
            state_d = S_OPND;
          end else if (is_rp && (depth_q != '0)) begin
            depth_d = depth_q - DEPTH_W'(1);
          end else begin
            state_d = S_ERR;
          end
        end
`endif

        S_ERR: begin
          state_d = S_ERR;
        end

        default: begin
          state_d = S_ERR;
        end
      endcase
    end
  end

  // Moore outputs straight from registers; S_ERR never satisfies the out condition.
  always_comb begin
    err     = (state_q == S_ERR);
    num_cnt = num_cnt_q;
`ifdef EXPR_CHECKER_PAREN_EN
    out     = ((state_q == S_NUM) || (state_q == S_CLOSE)) && (depth_q == '0);
    depth   = depth_q;
`else
    out     = (state_q == S_NUM);
    depth   = '0;
`endif
  end

endmodule

// File: tb/tb_expr_checker.sv
module tb_expr_checker;

  localparam int MAX_DIGITS = 4;
  localparam int MAX_DEPTH  = 3;
  localparam int CNT_W      = 8;
  localparam int DEPTH_W    = $clog2(MAX_DEPTH + 1);
`ifdef EXPR_CHECKER_PAREN_EN
  localparam bit PAREN = 1'b1;
`else
  localparam bit PAREN = 1'b0;
`endif

  logic               clk;
  logic               clr;
  logic               in_valid;
  logic [7:0]         in_c;
  logic               out;
  logic               err;
  logic [DEPTH_W-1:0] depth;
  logic [CNT_W-1:0]   num_cnt;

  int checks = 0;
  int errors = 0;

  expr_checker #(
    .MAX_DIGITS(MAX_DIGITS),
    .MAX_DEPTH (MAX_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .in_valid(in_valid),
    .in      (in_c),
    .out     (out),
    .err     (err),
    .depth   (depth),
    .num_cnt (num_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         c;
    bit         v;
    logic [7:0] ch;
    bit         o;
    bit         e;
    int         d;
    int         n;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit c, input bit v, input logic [7:0] ch,
                     input bit o, input bit e, input int d, input int n);
    vec_t x;
    x.c = c; x.v = v; x.ch = ch; x.o = o; x.e = e; x.d = d; x.n = n;
    tbl.push_back(x);
  endtask

  task automatic drive(input bit c, input bit v, input logic [7:0] ch);
    @(negedge clk);
    clr = c; in_valid = v; in_c = ch;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input bit o, input bit e, input int d, input int n);
    checks++;
    if (out !== o || err !== e || int'(depth) != d || int'(num_cnt) != n) begin
      errors++;
      $display("FAIL %s: got out=%0b err=%0b depth=%0d num_cnt=%0d, want out=%0b err=%0b depth=%0d num_cnt=%0d",
               name, out, err, depth, num_cnt, o, e, d, n);
    end
  endtask

  // Reference: re-scan the whole consumed history from scratch against the grammar.
  logic [7:0] hist_q[$];

  function automatic bit c_dig(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction
  function automatic bit c_op(input logic [7:0] c);
    return c == "+" || c == "-" || c == "*" || c == "/";
  endfunction

  function automatic void model(output bit o, output bit e, output int d, output int n);
    bit         have_prev = 0;
    logic [7:0] prev = 8'h00;
    int         run = 0;
    bit         want_opnd;
    e = 0; d = 0; n = 0;
    for (int i = 0; i < hist_q.size(); i++) begin
      logic [7:0] c = hist_q[i];
      want_opnd = !have_prev || c_op(prev) || prev == "(";
      if (c_dig(c)) begin
        if (want_opnd) begin
          run = 1;
          if (n < (1 << CNT_W) - 1) n++;
        end else if (c_dig(prev) && run < MAX_DIGITS) run++;
        else e = 1;
      end else if (c_op(c)) begin
        if (c_dig(prev) || prev == ")") run = 0;
        else e = 1;
      end else if (PAREN && c == "(") begin
        if (want_opnd && d < MAX_DEPTH) d++;
        else e = 1;
      end else if (PAREN && c == ")") begin
        if ((c_dig(prev) || prev == ")") && d > 0) d--;
        else e = 1;
      end else begin
        e = 1;
      end
      if (e) break;
      prev = c;
      have_prev = 1;
    end
    o = !e && have_prev && (c_dig(prev) || (PAREN && prev == ")")) && d == 0;
  endfunction

  initial begin
    clr = 1'b1; in_valid = 1'b0; in_c = 8'h00;

    // Reset state
    add(1,0,"A", 0,0,0,0);
    // "12+3*45"
    add(0,1,"1", 1,0,0,1); add(0,1,"2", 1,0,0,1); add(0,1,"+", 0,0,0,1);
    add(0,1,"3", 1,0,0,2); add(0,1,"*", 0,0,0,2); add(0,1,"4", 1,0,0,3);
    add(0,1,"5", 1,0,0,3);
    // "12345": fifth digit errors, further chars stay in error
    add(1,0,"A", 0,0,0,0);
    add(0,1,"1", 1,0,0,1); add(0,1,"2", 1,0,0,1); add(0,1,"3", 1,0,0,1);
    add(0,1,"4", 1,0,0,1); add(0,1,"5", 0,1,0,1); add(0,1,"6", 0,1,0,1);
    add(0,1,"+", 0,1,0,1); add(0,1,"7", 0,1,0,1);
    // ")" first
    add(1,0,"A", 0,0,0,0); add(0,1,")", 0,1,0,0);
    // "3+" then "+"
    add(1,0,"A", 0,0,0,0);
    add(0,1,"3", 1,0,0,1); add(0,1,"+", 0,0,0,1); add(0,1,"+", 0,1,0,1);
    // "1+2" with gaps and junk on in
    add(1,0,"A", 0,0,0,0);
    add(0,1,"1", 1,0,0,1); add(0,0,8'h41, 1,0,0,1); add(0,0,8'h41, 1,0,0,1);
    add(0,1,"+", 0,0,0,1); add(0,0,8'h41, 0,0,0,1); add(0,1,"2", 1,0,0,2);
    // Leading zeros and the other two operators
    add(1,0,"A", 0,0,0,0);
    add(0,1,"0", 1,0,0,1); add(0,1,"0", 1,0,0,1); add(0,1,"7", 1,0,0,1);
    add(0,1,"-", 0,0,0,1); add(0,1,"8", 1,0,0,2); add(0,1,"/", 0,0,0,2);
    add(0,1,"9", 1,0,0,3);
    // Illegal character
    add(1,0,"A", 0,0,0,0); add(0,1,"2", 1,0,0,1); add(0,1," ", 0,1,0,1);
    // "4*(" then clr together with a valid '5'
    add(1,0,"A", 0,0,0,0);
    add(0,1,"4", 1,0,0,1); add(0,1,"*", 0,0,0,1);
    if (PAREN) add(0,1,"(", 0,0,1,1);
    else       add(0,1,"(", 0,1,0,1);
    add(1,1,"5", 0,0,0,0); add(0,0,"5", 0,0,0,0);
    if (PAREN) begin
      // "((1+2)*3)"
      add(0,1,"(", 0,0,1,0); add(0,1,"(", 0,0,2,0); add(0,1,"1", 0,0,2,1);
      add(0,1,"+", 0,0,2,1); add(0,1,"2", 0,0,2,2); add(0,1,")", 0,0,1,2);
      add(0,1,"*", 0,0,1,2); add(0,1,"3", 0,0,1,3); add(0,1,")", 1,0,0,3);
      // Nesting limit
      add(1,0,"A", 0,0,0,0);
      add(0,1,"(", 0,0,1,0); add(0,1,"(", 0,0,2,0); add(0,1,"(", 0,0,3,0);
      add(0,1,"(", 0,1,3,0);
      // Unbalanced close and digit after ')'
      add(1,0,"A", 0,0,0,0);
      add(0,1,"(", 0,0,1,0); add(0,1,"5", 0,0,1,1); add(0,1,")", 1,0,0,1);
      add(0,1,")", 0,1,0,1);
      add(1,0,"A", 0,0,0,0);
      add(0,1,"(", 0,0,1,0); add(0,1,"5", 0,0,1,1); add(0,1,")", 1,0,0,1);
      add(0,1,"6", 0,1,0,1);
    end else begin
      add(1,0,"A", 0,0,0,0); add(0,1,"1", 1,0,0,1); add(0,1,")", 0,1,0,1);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].c, tbl[i].v, tbl[i].ch);
      check($sformatf("vec%0d", i), tbl[i].o, tbl[i].e, tbl[i].d, tbl[i].n);
    end

    // Saturation of the operand count over 300 numbers
    drive(1, 0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      drive(0, 1, "1");
      drive(0, 1, "+");
    end
    check("sat_after_op", 0, 0, 0, (1 << CNT_W) - 1);
    drive(0, 1, "7");
    check("sat_final_num", 1, 0, 0, (1 << CNT_W) - 1);

    // Random stimulus against the history-rescan model
    hist_q.delete();
    drive(1, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      bit         c, v, mo, me;
      int         md, mn, r;
      logic [7:0] ch;
      model(mo, me, md, mn);
      if (me || hist_q.size() > 40) c = ($urandom_range(0, 99) < 30);
      else                          c = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 80);
      r = $urandom_range(0, 99);
      if (r < 45)      ch = 8'("0" + $urandom_range(0, 9));
      else if (r < 70) begin
        case ($urandom_range(0, 3))
          0: ch = "+";
          1: ch = "-";
          2: ch = "*";
          default: ch = "/";
        endcase
      end
      else if (r < 80) ch = "(";
      else if (r < 90) ch = ")";
      else             ch = 8'($urandom_range(0, 255));
      drive(c, v, ch);
      if (c) hist_q.delete();
      else if (v) hist_q.push_back(ch);
      model(mo, me, md, mn);
      check("random", mo, me, md, mn);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
